// File: rtl/apb_gpi_irq_if.sv
// APB bus bundle for the apb_gpi_irq peripheral.
// The master drives address, control and write data. The slave returns read data and ready.
interface apb_gpi_irq_if;
  logic [4:0]  PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_gpi_irq.sv
// APB general-purpose input block with per-pin synchronisers and edge detection.
// It has sticky write-1-to-clear edge status and a level interrupt output.
module apb_gpi_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_gpi_irq_if.slave       apb,
  input  logic [WIDTH-1:0]   gpi,
  output logic               irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_HOLD
  } state_t;

  state_t                              state_q;
  logic                                pready_q;
  logic [31:0]                         prdata_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q;
  logic [WIDTH-1:0]                    sd_q;
  logic [WIDTH-1:0]                    cr_q, cr_d;
  logic [WIDTH-1:0]                    rie_q, rie_d;
  logic [WIDTH-1:0]                    fie_q, fie_d;
  logic [WIDTH-1:0]                    isr_q, isr_d;
  logic [WIDTH-1:0]                    s;
  logic [WIDTH-1:0]                    evt;
  logic [WIDTH-1:0]                    wdat;
  logic [2:0]                          reg_sel;
  logic [31:0]                         rd_word;
  logic                                access;
  logic                                commit;
  logic                                unused_bits;

  assign access      = apb.PSEL && apb.PENABLE;
  assign reg_sel     = apb.PADDR[4:2];
  assign wdat        = apb.PWDATA[WIDTH-1:0];
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  // Synchroniser chain; sd_q keeps running whatever CR says, so enabling a pin sees no stale edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_q <= '0;
      sd_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpi};
      sd_q   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s   = sync_q[SYNC_STAGES-1];
  assign evt = cr_q & ((s & ~sd_q & rie_q) | (~s & sd_q & fie_q));

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      3'd0:    rd_word[WIDTH-1:0] = cr_q;
      3'd1:    rd_word[WIDTH-1:0] = s & cr_q;
      3'd2:    rd_word[WIDTH-1:0] = rie_q;
      3'd3:    rd_word[WIDTH-1:0] = fie_q;
      3'd4:    rd_word[WIDTH-1:0] = isr_q;
      default: rd_word = '0;
    endcase
  end

  // One wait state. PREADY pulses once per transfer, then the FSM holds until the master ends the access phase.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pready_q <= 1'b0;
          if (access) begin
            state_q  <= ST_ACK;
            pready_q <= 1'b1;
            if (!apb.PWRITE) prdata_q <= rd_word;
          end
        end
        ST_ACK: begin
          pready_q <= 1'b0;
          state_q  <= access ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          pready_q <= 1'b0;
          if (!access) state_q <= ST_IDLE;
        end
        default: begin
          pready_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign commit = (state_q == ST_ACK) && access && apb.PWRITE;

  // Writes land on the edge that ends the ready cycle. A new edge event beats a same-cycle clear.
  always_comb begin
    cr_d  = cr_q;
    rie_d = rie_q;
    fie_d = fie_q;
    isr_d = isr_q;
    if (commit) begin
      case (reg_sel)
        3'd0:    cr_d  = wdat;
        3'd2:    rie_d = wdat;
        3'd3:    fie_d = wdat;
        3'd4:    isr_d = isr_q & ~wdat;
        default: ;
      endcase
    end
    isr_d = isr_d | evt;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cr_q  <= '0;
      rie_q <= '0;
      fie_q <= '0;
      isr_q <= '0;
    end else begin
      cr_q  <= cr_d;
      rie_q <= rie_d;
      fie_q <= fie_d;
      isr_q <= isr_d;
    end
  end

  assign apb.PREADY = pready_q;
  assign apb.PRDATA = prdata_q;
  assign irq        = |isr_q;

endmodule

// File: tb/tb_apb_gpi_irq.sv
// Randomised scoreboard bench for apb_gpi_irq with a register-level reference model.
// It also runs directed timing checks for edge latency, set/clear collision, held access and mid-transfer reset.
module tb_apb_gpi_irq;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;

  logic             PCLK   = 1'b0;
  logic             PRESET = 1'b1;
  logic [WIDTH-1:0] gpi    = '0;
  logic             irq;

  apb_gpi_irq_if bus();

  apb_gpi_irq #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (bus.slave),
    .gpi    (gpi),
    .irq    (irq)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_read;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [WIDTH-1:0] m_cr = '0, m_rie = '0, m_fie = '0, m_isr = '0, m_gpi = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    logic [31:0] r;
    r = '0;
    case (addr[4:2])
      3'd0: r[WIDTH-1:0] = m_cr;
      3'd1: r[WIDTH-1:0] = m_gpi & m_cr;
      3'd2: r[WIDTH-1:0] = m_rie;
      3'd3: r[WIDTH-1:0] = m_fie;
      3'd4: r[WIDTH-1:0] = m_isr;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data);
    case (addr[4:2])
      3'd0: m_cr  = data[WIDTH-1:0];
      3'd2: m_rie = data[WIDTH-1:0];
      3'd3: m_fie = data[WIDTH-1:0];
      3'd4: m_isr = m_isr & ~data[WIDTH-1:0];
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_cr = '0; m_rie = '0; m_fie = '0; m_isr = '0;
  endtask

  // Monitor: every ready pulse must match one queued transfer.
  always @(negedge PCLK) begin
    if (bus.PREADY === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready actual=1 required=0");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (e.is_read) check($sformatf("read_%02h", e.addr), bus.PRDATA, e.data);
      end
    end
  end

  task automatic bus_idle();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_xfer(input bit wr, input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    int   n;
    e.is_read = !wr;
    e.addr    = addr;
    e.data    = wr ? 32'h0 : model_read(addr);
    sbq.push_back(e);
    bus.PSEL = 1'b1; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = data; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1 bus.PENABLE = 1'b1;
    n = 0;
    @(negedge PCLK);
    while (bus.PREADY !== 1'b1 && n < 8) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 8) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout addr=%02h actual=0 required=1", addr);
      void'(sbq.pop_back());
    end
    @(posedge PCLK); #1 bus_idle();
    if (wr) model_write(addr, data);
  endtask

  task automatic set_gpi(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] rising, falling;
    rising  = v & ~m_gpi;
    falling = ~v & m_gpi;
    m_isr   = m_isr | (m_cr & ((rising & m_rie) | (falling & m_fie)));
    m_gpi   = v;
    gpi     = v;
    repeat (SYNC + 2) @(posedge PCLK);
    #1 check("irq_after_gpi", {31'b0, irq}, {31'b0, |m_isr});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PADDR = '0; bus.PWDATA = '0;
    bus_idle();

    // Reset state and reads of every register.
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", {31'b0, bus.PREADY}, 32'h0);
    check("rst_prdata", bus.PRDATA, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    for (int a = 0; a < 6; a++) apb_xfer(1'b0, 5'(a * 4), 32'h0);
    check("irq_idle", {31'b0, irq}, 32'h0);

    // Input data register with partial enable.
    apb_xfer(1'b1, 5'h00, 32'h0000_000F);
    set_gpi(8'hFF);
    apb_xfer(1'b0, 5'h04, 32'h0);
    apb_xfer(1'b1, 5'h00, 32'h0);
    apb_xfer(1'b0, 5'h04, 32'h0);

    // Rising edge latency: status appears on the third edge after the pin change.
    apb_xfer(1'b1, 5'h00, 32'hFF);
    apb_xfer(1'b1, 5'h08, 32'h01);
    set_gpi(8'h00);
    gpi = 8'h01; m_gpi = 8'h01;
    @(posedge PCLK); #1 check("lat_edge1", {31'b0, irq}, 32'h0);
    @(posedge PCLK); #1 check("lat_edge2", {31'b0, irq}, 32'h0);
    @(posedge PCLK); #1 check("lat_edge3", {31'b0, irq}, 32'h1);
    m_isr = m_isr | 8'h01;
    apb_xfer(1'b0, 5'h10, 32'h0);
    apb_xfer(1'b1, 5'h10, 32'h01);
    check("w1c_irq", {31'b0, irq}, 32'h0);
    apb_xfer(1'b0, 5'h10, 32'h0);

    // Falling edge on bit 7, rising edge on bit 6 without enable.
    apb_xfer(1'b1, 5'h0C, 32'h80);
    set_gpi(8'h81);
    set_gpi(8'h41);
    apb_xfer(1'b0, 5'h10, 32'h0);
    apb_xfer(1'b1, 5'h10, 32'hFF);

    // W1C committing on the same edge that a new rising event sets the bit.
    set_gpi(8'h40);
    begin
      exp_t e;
      e.is_read = 1'b0; e.addr = 5'h10; e.data = 32'h0;
      sbq.push_back(e);
    end
    gpi = 8'h41; m_gpi = 8'h41;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 5'h10; bus.PWDATA = 32'h01; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1 bus.PENABLE = 1'b1;
    @(posedge PCLK); #1 check("coll_pready", {31'b0, bus.PREADY}, 32'h1);
    @(posedge PCLK); #1 bus_idle();
    m_isr = m_isr | 8'h01;
    check("coll_irq", {31'b0, irq}, 32'h1);
    apb_xfer(1'b0, 5'h10, 32'h0);
    apb_xfer(1'b1, 5'h10, 32'h01);
    apb_xfer(1'b0, 5'h10, 32'h0);

    // Access phase held for four cycles: a single ready pulse.
    begin
      exp_t e;
      e.is_read = 1'b0; e.addr = 5'h00; e.data = 32'h0;
      sbq.push_back(e);
    end
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 5'h00; bus.PWDATA = 32'h55; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1 bus.PENABLE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check($sformatf("hold_pready_c%0d", i + 1), {31'b0, bus.PREADY}, (i == 1) ? 32'h1 : 32'h0);
    end
    @(posedge PCLK); #1 bus_idle();
    model_write(5'h00, 32'h55);
    apb_xfer(1'b0, 5'h00, 32'h0);

    // Reset during the ready cycle aborts the write.
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 5'h00; bus.PWDATA = 32'hAA; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1 bus.PENABLE = 1'b1;
    @(posedge PCLK); #1 check("abort_pready_before", {31'b0, bus.PREADY}, 32'h1);
    #1 PRESET = 1'b1;
    #1 check("abort_pready_now", {31'b0, bus.PREADY}, 32'h0);
    bus_idle();
    model_reset();
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    repeat (SYNC + 2) @(posedge PCLK);
    #1 check("abort_irq", {31'b0, irq}, 32'h0);
    apb_xfer(1'b0, 5'h00, 32'h0);

    // Randomised traffic against the reference model.
    for (int k = 0; k < 80; k++) begin
      logic [4:0]  ra;
      logic [31:0] rd;
      ra = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      rd = $urandom;
      case ($urandom_range(0, 4))
        0, 1: apb_xfer(1'b1, ra, rd);
        2:    apb_xfer(1'b0, ra, 32'h0);
        3:    set_gpi(WIDTH'($urandom));
        default: apb_xfer(1'b1, 5'h10, rd);
      endcase
    end
    for (int a = 0; a < 8; a++) apb_xfer(1'b0, 5'(a * 4), 32'h0);

    repeat (3) @(posedge PCLK);
    check("sb_drained", sbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_gpi_irq.md
Name: apb_gpi_irq

Overview:
- Parametrised APB general-purpose input peripheral; next generation of the 8-bit GPI slave.
- Generalises input width to WIDTH bits and adds a metastability synchroniser on every input.
- Adds per-bit rising/falling edge detection, a sticky write-1-to-clear interrupt status register and a single level interrupt output.
- Sits on the APB bus behind the decoder's PSEL, alongside the other peripherals; irq goes to the CPU interrupt input.

Parameters:
- WIDTH, 8, number of input pins; legal range 1..32.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; legal range >= 2.

Ports:
- PCLK  input  1  APB clock; single clock for the whole block.
- PRESET  input  1  asynchronous, active-high reset.
- PADDR  input  5  byte address; PADDR[4:2] selects the register; PADDR[1:0] ignored.
- PWRITE  input  1  1 = write, 0 = read.
- PENABLE  input  1  APB access phase.
- PWDATA  input  32  write data.
- PSEL  input  1  slave select.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer complete.
- gpi  input  WIDTH  asynchronous external inputs.
- irq  output  1  interrupt, active high, level.

Behaviour:
- Reset (asynchronous, PRESET=1): all registers, synchroniser flops and edge-history flops go to 0. PRDATA=0, PREADY=0, irq=0.
- Register map (register bits above WIDTH-1 read 0 and ignore writes):
  - 0x00 CR, RW: per-bit input enable.
  - 0x04 IDR, RO: synchronised gpi AND CR. Disabled bits read 0, never Z.
  - 0x08 RIE, RW: rising-edge interrupt enable.
  - 0x0C FIE, RW: falling-edge interrupt enable.
  - 0x10 ISR, RW1C: sticky edge status. Writing 1 clears a bit; writing 0 has no effect.
  - 0x14..0x1C: reserved; read 0, writes ignored.
- APB handshake:
  - Exactly one wait state. The first cycle with PSEL&&PENABLE has PREADY=0; the next cycle has PREADY=1.
  - PREADY is high for exactly one cycle per transfer and returns to 0 even if PSEL/PENABLE stay high. A new transfer needs a fresh setup phase.
  - Write side effects commit at the clock edge that ends the PREADY=1 cycle.
  - PRDATA is valid while PREADY=1 and holds its last value otherwise.
  - With PSEL=0, no register changes.
- Synchroniser: gpi passes through SYNC_STAGES flops; s = last stage, s_d = s delayed one cycle.
  - A gpi change held stable first appears in IDR after SYNC_STAGES rising edges.
- Edge events (per bit i, only when CR[i]=1):
  - rise[i] = s[i] & ~s_d[i] & RIE[i]
  - fall[i] = ~s[i] & s_d[i] & FIE[i]
  - An event sets ISR[i] at the next edge, i.e. SYNC_STAGES+1 edges after the gpi change.
  - s_d tracks s regardless of CR, so enabling a bit never generates a spurious edge from stale history.
- Status set/clear collision: an event and a W1C on the same bit in the same cycle leave ISR[i]=1 (set wins).
- Enable changes: clearing RIE, FIE or CR does not clear existing ISR bits.
- irq = |ISR, combinational from the ISR register; no extra latency beyond ISR.
- Pulse narrower than one PCLK period: may be missed; no requirement.
- Reset mid-transfer: aborts the transfer, PREADY drops to 0 immediately, nothing commits.

Test Plan:
- Reset then read all six addresses (0x00..0x14) -> each returns 0x0000_0000, PREADY high exactly one cycle per read, irq=0.
- Write CR=0x0F, drive gpi=0xFF, wait 3 cycles, read IDR -> 0x0000_000F. Then CR=0x00 -> IDR reads 0x0.
- CR=0xFF, RIE=0x01, gpi[0] 0->1 -> ISR=0x01 exactly SYNC_STAGES+1 (=3) edges after the change, irq=1. Write ISR=0x01 -> ISR=0, irq=0.
- CR=0xFF, FIE=0x80, toggle gpi[7] 1->0 -> ISR=0x80. Also toggle gpi[6] 0->1 with RIE=0 -> ISR[6] stays 0.
- Schedule a W1C of ISR=0x01 in the same cycle a new rising edge on bit 0 is detected -> ISR[0] remains 1, irq stays 1.
- Hold PSEL=PENABLE=1 for 4 cycles on a write of CR=0x55 -> PREADY pulses once (cycle 2 only), CR=0x55. Assert PRESET mid-transfer -> PREADY=0 at once, CR=0.
